mem_port_arbiter: RTL and testbench

- Arbitrates a single shared memory/AXI-bridge port between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read/write) in the npc pipeline.
- Latches the winning request and sequences it through a request/accept/response handshake. Returns data and a one-cycle done pulse to the owner.
- Drives per-requester busy flags so the mem stage suppresses re-issue while a transaction is in flight.
- Enforces a response timeout.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Shared memory/AXI-bridge port between the npc arbiter and the memory side.
// Signal names keep the arbiter's point of view: *_o leave the arbiter,
// *_i enter it.
//   mem_req_o    request valid, held until mem_ready_i
//   mem_we_o     1 = write, 0 = read
//   mem_addr_o   64-bit address
//   mem_wdata_o  64-bit write data (0 for reads)
//   mem_wmask_o  byte mask, bit i = byte i (0 for reads)
//   mem_ready_i  port accepts the request this cycle
//   mem_resp_i   response valid (read data or write ack)
//   mem_rdata_i  response read data
// Modports: master = arbiter side, slave = memory side.
interface mem_port_arbiter_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_ready_i;
    logic        mem_resp_i;
    logic [63:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_ready_i, mem_resp_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_ready_i, mem_resp_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF, read only) and
// load/store (LS, read/write). Requests are sampled in IDLE only; the winner's
// fields are latched and walked through REQ (request until accepted), WAIT
// (until response) and DONE (one-cycle done pulse to the owner). A timeout on
// REQ+WAIT aborts the transaction with err_o and a zero result.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   if_req_i/if_addr_i    IF read request and address
//   if_rdata_o/if_done_o  IF result and completion pulse
//   if_busy_o             IF transaction in REQ/WAIT
//   ls_ren_i/ls_wen_i     LS read / write request
//   ls_addr_i/ls_wdata_i/ls_wmask_i  LS address, write data, byte mask
//   ls_rdata_o/ls_done_o  LS result and completion pulse
//   ls_busy_o             LS transaction in REQ/WAIT
//   mem                   memory port (master modport)
//   err_o                 timeout abort, pulses with the DONE cycle
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    output logic [63:0] if_rdata_o,
    output logic        if_done_o,
    output logic        if_busy_o,
    input  logic        ls_ren_i,
    input  logic        ls_wen_i,
    input  logic [63:0] ls_addr_i,
    input  logic [63:0] ls_wdata_i,
    input  logic [7:0]  ls_wmask_i,
    output logic [63:0] ls_rdata_o,
    output logic        ls_done_o,
    output logic        ls_busy_o,
    mem_port_arbiter_if.master mem,
    output logic        err_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic        OWN_IF  = 1'b0;
    localparam logic        OWN_LS  = 1'b1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        owner_q, last_grant_q;
    logic        we_q, fwd_q, err_q;
    logic [63:0] addr_q, wdata_q;
    logic [7:0]  wmask_q;
    logic [15:0] cnt_q;
    logic [63:0] if_rdata_q, ls_rdata_q;

    logic        if_act, ls_act, grant_ls;
    logic        in_flight, timeout_hit, resp_take, to_abort;
    logic [63:0] result_d;

    assign if_act    = if_req_i;
    assign ls_act    = ls_ren_i | ls_wen_i;
    // On a tie the requester that did not win last time gets the port.
    assign grant_ls  = ls_act & (~if_act | (last_grant_q == OWN_IF));

    assign in_flight   = (state_q == S_REQ) || (state_q == S_WAIT);
    assign timeout_hit = in_flight && (cnt_q == TO_LAST);
    // Responses only count in WAIT, so one can never land with mem_ready_i.
    assign resp_take   = (state_q == S_WAIT) && mem.mem_resp_i;
    // A response arriving on the timeout cycle completes normally.
    assign to_abort    = timeout_hit && !resp_take;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (if_act || ls_act) state_d = S_REQ;
            S_REQ: begin
                if (to_abort)              state_d = S_DONE;
                else if (mem.mem_ready_i)  state_d = S_WAIT;
            end
            S_WAIT: if (resp_take || to_abort) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ren&wen is issued as a write whose read result is the written data.
    always_comb begin
        result_d = 64'd0;
        if (resp_take) begin
            if (fwd_q)      result_d = wdata_q;
            else if (!we_q) result_d = mem.mem_rdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            we_q         <= 1'b0;
            fwd_q        <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            wmask_q      <= 8'd0;
            cnt_q        <= 16'd0;
            if_rdata_q   <= 64'd0;
            ls_rdata_q   <= 64'd0;
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE && (if_act || ls_act)) begin
                owner_q      <= grant_ls;
                last_grant_q <= grant_ls;
                cnt_q        <= 16'd0;
                if (grant_ls) begin
                    we_q    <= ls_wen_i;
                    fwd_q   <= ls_ren_i & ls_wen_i;
                    addr_q  <= ls_addr_i;
                    wdata_q <= ls_wen_i ? ls_wdata_i : 64'd0;
                    wmask_q <= ls_wen_i ? ls_wmask_i : 8'd0;
                end else begin
                    we_q    <= 1'b0;
                    fwd_q   <= 1'b0;
                    addr_q  <= if_addr_i;
                    wdata_q <= 64'd0;
                    wmask_q <= 8'd0;
                end
            end else if (in_flight) begin
                cnt_q <= cnt_q + 16'd1;
            end

            // Result and error are captured on entry to DONE; each rdata
            // register then holds until its owner's next completion.
            if (state_d == S_DONE && state_q != S_DONE) begin
                err_q <= to_abort;
                if (owner_q == OWN_LS) ls_rdata_q <= result_d;
                else                   if_rdata_q <= result_d;
            end
        end
    end

    assign mem.mem_req_o   = (state_q == S_REQ);
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign mem.mem_wmask_o = wmask_q;

    assign if_done_o  = (state_q == S_DONE) && (owner_q == OWN_IF);
    assign ls_done_o  = (state_q == S_DONE) && (owner_q == OWN_LS);
    assign err_o      = (state_q == S_DONE) && err_q;
    assign if_busy_o  = in_flight && (owner_q == OWN_IF);
    assign ls_busy_o  = in_flight && (owner_q == OWN_LS);
    assign if_rdata_o = if_rdata_q;
    assign ls_rdata_o = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed stimulus, a memory-port model with
// programmable ready/response delay, and a scoreboard monitor that checks
// every presented request and every done pulse against queued expectations.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [63:0] if_addr_i;
    logic [63:0] if_rdata_o;
    logic        if_done_o, if_busy_o;
    logic        ls_ren_i, ls_wen_i;
    logic [63:0] ls_addr_i, ls_wdata_i;
    logic [7:0]  ls_wmask_i;
    logic [63:0] ls_rdata_o;
    logic        ls_done_o, ls_busy_o;
    logic        err_o;

    mem_port_arbiter_if mif();

    mem_port_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_done_o(if_done_o), .if_busy_o(if_busy_o),
        .ls_ren_i(ls_ren_i), .ls_wen_i(ls_wen_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i), .ls_rdata_o(ls_rdata_o),
        .ls_done_o(ls_done_o), .ls_busy_o(ls_busy_o),
        .mem(mif), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic ls; logic [63:0] rdata; logic err; } done_t;
    typedef struct { logic [63:0] addr; logic we; logic [63:0] wdata; logic [7:0] wmask; } req_t;

    done_t exp_done[$];
    req_t  exp_req[$];
    int    checks = 0;
    int    errors = 0;

    // memory model controls
    int          ready_delay = 0;
    int          resp_delay  = 0;
    bit          resp_en     = 1'b1;
    bit          stray_resp  = 1'b0;
    logic [63:0] rd_data     = 64'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic req_t mk_req(logic [63:0] a, logic we, logic [63:0] wd, logic [7:0] wm);
        req_t r;
        r.addr = a; r.we = we; r.wdata = wd; r.wmask = wm;
        return r;
    endfunction

    function automatic done_t mk_done(logic ls, logic [63:0] d, logic e);
        done_t r;
        r.ls = ls; r.rdata = d; r.err = e;
        return r;
    endfunction

    // Memory-port model: inputs change on the falling edge only.
    initial begin
        int stall = 0;
        int rcnt  = 0;
        bit waiting = 1'b0;
        mif.mem_ready_i = 1'b0;
        mif.mem_resp_i  = 1'b0;
        mif.mem_rdata_i = 64'd0;
        forever begin
            @(negedge clk);
            mif.mem_ready_i = 1'b0;
            mif.mem_resp_i  = 1'b0;
            mif.mem_rdata_i = ~rd_data;
            if (rst) begin
                waiting = 1'b0;
                stall   = 0;
            end else if (mif.mem_req_o && !waiting) begin
                if (stall >= ready_delay) begin
                    mif.mem_ready_i = 1'b1;
                    waiting = 1'b1;
                    stall   = 0;
                    rcnt    = 0;
                end else begin
                    stall++;
                end
            end else if (waiting && !mif.mem_req_o) begin
                if (if_done_o || ls_done_o) begin
                    waiting = 1'b0;
                end else if (resp_en && rcnt >= resp_delay) begin
                    mif.mem_resp_i  = 1'b1;
                    mif.mem_rdata_i = rd_data;
                    waiting = 1'b0;
                end else begin
                    rcnt++;
                end
            end
            if (stray_resp) begin
                mif.mem_resp_i  = 1'b1;
                mif.mem_rdata_i = 64'hbad0_bad0_bad0_bad0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_done.delete();
                exp_req.delete();
            end else begin
                if (mif.mem_req_o) begin
                    if (exp_req.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_unexpected actual addr=%0h required none", mif.mem_addr_o);
                    end else begin
                        check("req_addr",  mif.mem_addr_o,          exp_req[0].addr);
                        check("req_we",    64'(mif.mem_we_o),       64'(exp_req[0].we));
                        check("req_wdata", mif.mem_wdata_o,         exp_req[0].wdata);
                        check("req_wmask", 64'(mif.mem_wmask_o),    64'(exp_req[0].wmask));
                        if (mif.mem_ready_i) void'(exp_req.pop_front());
                    end
                end
                if (if_done_o || ls_done_o) begin
                    if (exp_done.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected actual if=%0d ls=%0d required none", if_done_o, ls_done_o);
                    end else begin
                        e = exp_done.pop_front();
                        check("done_if",    64'(if_done_o), 64'(!e.ls));
                        check("done_ls",    64'(ls_done_o), 64'(e.ls));
                        check("done_rdata", e.ls ? ls_rdata_o : if_rdata_o, e.rdata);
                        check("done_err",   64'(err_o), 64'(e.err));
                    end
                end else if (err_o) begin
                    checks++; errors++;
                    $display("FAIL err_without_done actual=1 required=0");
                end
            end
        end
    end

    task automatic wait_done(input int budget, output bit got_if, output bit got_ls);
        got_if = 1'b0;
        got_ls = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (if_done_o || ls_done_o) begin
                got_if = if_done_o;
                got_ls = ls_done_o;
                if (if_done_o) if_req_i = 1'b0;
                if (ls_done_o) begin ls_ren_i = 1'b0; ls_wen_i = 1'b0; end
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_done timeout actual=no done required=done within %0d cycles", budget);
    endtask

    task automatic tie_pair(input logic [63:0] a_if, input logic [63:0] d_if,
                            input logic [63:0] a_ls, input logic [63:0] d_ls);
        bit gi, gl;
        @(negedge clk);
        rd_data = d_ls;
        exp_req.push_back(mk_req(a_ls, 1'b0, 64'd0, 8'd0));
        exp_req.push_back(mk_req(a_if, 1'b0, 64'd0, 8'd0));
        exp_done.push_back(mk_done(1'b1, d_ls, 1'b0));
        exp_done.push_back(mk_done(1'b0, d_if, 1'b0));
        if_req_i = 1'b1; if_addr_i = a_if;
        ls_ren_i = 1'b1; ls_addr_i = a_ls;
        wait_done(60, gi, gl);
        check("tie_first_ls", 64'(gl), 64'd1);
        rd_data = d_if;
        wait_done(60, gi, gl);
        check("tie_second_if", 64'(gi), 64'd1);
    endtask

    initial begin
        bit gi, gl;
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = 64'd0;
        ls_ren_i = 1'b0; ls_wen_i = 1'b0;
        ls_addr_i = 64'd0; ls_wdata_i = 64'd0; ls_wmask_i = 8'd0;

        // reset state
        #2;
        check("rst_mem_req",  64'(mif.mem_req_o), 64'd0);
        check("rst_mem_we",   64'(mif.mem_we_o),  64'd0);
        check("rst_mem_addr", mif.mem_addr_o,     64'd0);
        check("rst_if_busy",  64'(if_busy_o),     64'd0);
        check("rst_ls_busy",  64'(ls_busy_o),     64'd0);
        check("rst_if_done",  64'(if_done_o),     64'd0);
        check("rst_ls_done",  64'(ls_done_o),     64'd0);
        check("rst_err",      64'(err_o),         64'd0);
        check("rst_if_rdata", if_rdata_o,         64'd0);
        check("rst_ls_rdata", ls_rdata_o,         64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // tie arbitration: LS first after reset, and again on the next tie
        tie_pair(64'h8000_0100, 64'h5555_6666_7777_8888, 64'h8000_2000, 64'h1111_2222_3333_4444);
        tie_pair(64'h8000_0110, 64'hfedc_ba98_7654_3210, 64'h8000_2008, 64'h0123_4567_89ab_cdef);

        // single IF read at minimum latency
        @(negedge clk);
        rd_data = 64'h0000_0013_0000_0093;
        exp_req.push_back(mk_req(64'h8000_0000, 1'b0, 64'd0, 8'd0));
        exp_done.push_back(mk_done(1'b0, 64'h0000_0013_0000_0093, 1'b0));
        if_req_i = 1'b1; if_addr_i = 64'h8000_0000;
        @(posedge clk); #1;
        check("lat_n1_busy", 64'(if_busy_o), 64'd1);
        check("lat_n1_req",  64'(mif.mem_req_o), 64'd1);
        @(posedge clk); #1;
        check("lat_n2_busy", 64'(if_busy_o), 64'd1);
        check("lat_n2_req",  64'(mif.mem_req_o), 64'd0);
        @(posedge clk); #1;
        check("lat_n3_done", 64'(if_done_o), 64'd1);
        check("lat_n3_busy", 64'(if_busy_o), 64'd0);
        check("lat_n3_data", if_rdata_o, 64'h0000_0013_0000_0093);
        @(negedge clk);
        if_req_i = 1'b0;

        // LS write with 3 stall cycles; inputs change after grant
        @(negedge clk);
        ready_delay = 3;
        rd_data = 64'hffff_ffff_ffff_ffff;
        exp_req.push_back(mk_req(64'ha000_03f8, 1'b1, 64'h41, 8'h01));
        exp_done.push_back(mk_done(1'b1, 64'd0, 1'b0));
        ls_wen_i = 1'b1; ls_addr_i = 64'ha000_03f8; ls_wdata_i = 64'h41; ls_wmask_i = 8'h01;
        @(negedge clk);
        ls_addr_i = 64'h1234; ls_wdata_i = 64'h99; ls_wmask_i = 8'hff;
        wait_done(60, gi, gl);
        check("wr_done_ls", 64'(gl), 64'd1);
        check("if_rdata_hold", if_rdata_o, 64'h0000_0013_0000_0093);
        ready_delay = 0;

        // ren&wen: issued as a write, read result forwarded from wdata
        @(negedge clk);
        rd_data = 64'h5a5a_5a5a_5a5a_5a5a;
        exp_req.push_back(mk_req(64'h8000_1000, 1'b1, 64'hdead_beef, 8'hff));
        exp_done.push_back(mk_done(1'b1, 64'hdead_beef, 1'b0));
        ls_ren_i = 1'b1; ls_wen_i = 1'b1;
        ls_addr_i = 64'h8000_1000; ls_wdata_i = 64'hdead_beef; ls_wmask_i = 8'hff;
        wait_done(60, gi, gl);

        // timeout: ready given, no response
        @(negedge clk);
        resp_en = 1'b0;
        rd_data = 64'h7777_7777_7777_7777;
        exp_req.push_back(mk_req(64'h8000_3000, 1'b0, 64'd0, 8'd0));
        exp_done.push_back(mk_done(1'b1, 64'd0, 1'b1));
        ls_ren_i = 1'b1; ls_addr_i = 64'h8000_3000;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("to_busy", 64'(ls_busy_o), 64'd1);
            check("to_no_done", 64'(ls_done_o), 64'd0);
        end
        @(posedge clk); #1;
        check("to_err",      64'(err_o), 64'd1);
        check("to_done",     64'(ls_done_o), 64'd1);
        check("to_req_drop", 64'(mif.mem_req_o), 64'd0);
        check("to_rdata",    ls_rdata_o, 64'd0);
        @(negedge clk);
        ls_ren_i = 1'b0;
        // stray response while idle
        @(posedge clk); #2;
        stray_resp = 1'b1;
        @(posedge clk); #2;
        stray_resp = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_ls_done", 64'(ls_done_o), 64'd0);
        check("stray_err",     64'(err_o), 64'd0);
        check("stray_busy",    64'(ls_busy_o), 64'd0);
        resp_en = 1'b1;

        // response on the timeout cycle wins
        @(negedge clk);
        resp_delay = 6;
        rd_data = 64'hcafe_f00d_0000_0001;
        exp_req.push_back(mk_req(64'h8000_0040, 1'b0, 64'd0, 8'd0));
        exp_done.push_back(mk_done(1'b0, 64'hcafe_f00d_0000_0001, 1'b0));
        if_req_i = 1'b1; if_addr_i = 64'h8000_0040;
        wait_done(60, gi, gl);
        check("race_done_if", 64'(gi), 64'd1);
        resp_delay = 0;

        // asynchronous reset while waiting for a response
        @(negedge clk);
        resp_en = 1'b0;
        exp_req.push_back(mk_req(64'h8000_0080, 1'b0, 64'd0, 8'd0));
        if_req_i = 1'b1; if_addr_i = 64'h8000_0080;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("arst_pre_busy", 64'(if_busy_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req",  64'(mif.mem_req_o), 64'd0);
        check("arst_busy", 64'(if_busy_o), 64'd0);
        check("arst_done", 64'(if_done_o), 64'd0);
        check("arst_addr", mif.mem_addr_o, 64'd0);
        if_req_i = 1'b0;
        @(negedge clk); #3;
        rst = 1'b0;
        resp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_done", 64'(if_done_o), 64'd0);
        tie_pair(64'h8000_0200, 64'h2468_ace0_1357_9bdf, 64'h8000_4000, 64'h0f0f_0f0f_f0f0_f0f0);

        repeat (3) @(negedge clk);
        check("sb_done_drained", 64'(exp_done.size()), 64'd0);
        check("sb_req_drained",  64'(exp_req.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
